// File: rtl/mat_result_collector.sv
// -----------------------------------------------------------------------------
// mat_result_collector
//
// Sink for the matrix-multiply result stream. Accepts ELEMENTS_NUM x
// ELEMENTS_NUM result elements serially over a valid/ready/last handshake,
// stores them row-major in an internal register array, and exposes the
// completed matrix to a host through a registered random-access read port
// until the host acknowledges it.
//
// Optional feature (macro COLLECTOR_PINGPONG_EN):
//   Two storage banks. Collection continues into the free bank while the
//   other one is held; the handshake only stalls when both banks are full.
//   result_valid and the read port always refer to the oldest held bank.
//   Without the macro a single bank with a COLLECT/HOLD FSM is built.
//
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   in_data       result element (RES_WIDTH bits)
//   in_valid      element valid
//   in_last       final element of the matrix
//   in_ready      collector can accept (drives upstream ready_out)
//   result_valid  a complete matrix is held and readable
//   result_ack    host releases the held matrix (single-cycle pulse)
//   rd_row/rd_col read address (IDX_W bits each); out-of-range reads give 0
//   rd_data       registered read data, 1-cycle latency
//   mat_count     completed matrices, 16-bit wrapping
//   err_last      sticky framing error
//   err_clr       clears err_last (a new error in the same cycle wins)
// -----------------------------------------------------------------------------
module mat_result_collector #(
    parameter  int ELEMENTS_NUM = 3,
    parameter  int DATA_WIDTH   = 4,
    localparam int RES_WIDTH    = DATA_WIDTH*2 + $clog2(ELEMENTS_NUM) + 1,
    localparam int IDX_W        = $clog2(ELEMENTS_NUM)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [RES_WIDTH-1:0] in_data,
    input  logic                 in_valid,
    input  logic                 in_last,
    output logic                 in_ready,
    output logic                 result_valid,
    input  logic                 result_ack,
    input  logic [IDX_W-1:0]     rd_row,
    input  logic [IDX_W-1:0]     rd_col,
    output logic [RES_WIDTH-1:0] rd_data,
    output logic [15:0]          mat_count,
    output logic                 err_last,
    input  logic                 err_clr
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ELEMENTS_NUM - 1);

    // Write pointer into the bank being collected
    logic [IDX_W-1:0]     row_q, row_d;
    logic [IDX_W-1:0]     col_q, col_d;
    logic [15:0]          mat_count_q, mat_count_d;
    logic                 err_last_q, err_last_d;
    logic [RES_WIDTH-1:0] rd_data_q, rd_data_d;

    logic                 accept;
    logic                 at_end;
    logic                 complete;
    logic                 frame_err;
    logic                 wr_en;

    // Read address handling: indices that do not exist read as zero; the
    // array index itself is clamped so it never leaves the array.
    logic                 rd_in_range;
    logic [IDX_W-1:0]     rd_r_idx;
    logic [IDX_W-1:0]     rd_c_idx;
    logic [RES_WIDTH-1:0] rd_word;

    assign rd_in_range = (int'(rd_row) < ELEMENTS_NUM) && (int'(rd_col) < ELEMENTS_NUM);
    assign rd_r_idx    = rd_in_range ? rd_row : '0;
    assign rd_c_idx    = rd_in_range ? rd_col : '0;

    assign accept = in_valid & in_ready;
    assign at_end = (row_q == LAST_IDX) && (col_q == LAST_IDX);

    // -------------------------------------------------------------------------
    // Write pointer, completion, framing and counters
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so
        // no path leaves it unassigned and no latch is inferred.
        row_d       = row_q;
        col_d       = col_q;
        mat_count_d = mat_count_q;
        wr_en       = 1'b0;
        complete    = 1'b0;
        frame_err   = 1'b0;

        if (accept) begin
            wr_en = 1'b1;
            if (at_end) begin
                // Final position: the matrix completes even without in_last,
                // but the missing marker is flagged.
                complete    = 1'b1;
                frame_err   = ~in_last;
                row_d       = '0;
                col_d       = '0;
                mat_count_d = mat_count_q + 16'd1;
            end else if (in_last) begin
                // Early last: the beat is stored but the partial matrix is
                // abandoned and collection restarts at (0,0).
                frame_err = 1'b1;
                row_d     = '0;
                col_d     = '0;
            end else if (col_q == LAST_IDX) begin
                col_d = '0;
                row_d = row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end

        // A new error outranks a simultaneous clear.
        err_last_d = frame_err | (err_last_q & ~err_clr);
        rd_data_d  = rd_in_range ? rd_word : '0;
    end

`ifdef COLLECTOR_PINGPONG_EN
    // -------------------------------------------------------------------------
    // Two-bank storage. wr_bank_q is the bank being collected; rd_bank_q is
    // the oldest held bank, or equals wr_bank_q when nothing is held.
    // -------------------------------------------------------------------------
    logic [RES_WIDTH-1:0] mem_q [2][ELEMENTS_NUM][ELEMENTS_NUM];
    logic [1:0]           full_q, full_d;
    logic                 wr_bank_q, wr_bank_d;
    logic                 rd_bank_q, rd_bank_d;

    always_comb begin
        full_d    = full_q;
        wr_bank_d = wr_bank_q;
        rd_bank_d = rd_bank_q;
        // Ack frees the oldest bank; reading moves on to the other one, which
        // is either still held or the bank that is being collected.
        if (result_ack && full_q[rd_bank_q]) begin
            full_d[rd_bank_q] = 1'b0;
            rd_bank_d         = ~rd_bank_q;
        end
        // Completion always lands in the free bank, so it never collides with
        // the bank an ack in the same cycle is releasing.
        if (complete) begin
            full_d[wr_bank_q] = 1'b1;
            wr_bank_d         = ~wr_bank_q;
        end
    end

    assign in_ready     = ~full_q[wr_bank_q];
    assign result_valid = full_q[rd_bank_q];
    assign rd_word      = mem_q[rd_bank_q][rd_r_idx][rd_c_idx];

    always_ff @(posedge clk) begin
        if (rst) begin
            full_q    <= '0;
            wr_bank_q <= 1'b0;
            rd_bank_q <= 1'b0;
        end else begin
            full_q    <= full_d;
            wr_bank_q <= wr_bank_d;
            rd_bank_q <= rd_bank_d;
        end
    end

    // NOTE: the storage array has no reset; its contents are undefined until
    // written, and leaving it off the reset net keeps it plain registers.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_bank_q][row_q][col_q] <= in_data;
        end
    end
`else
    // -------------------------------------------------------------------------
    // Single-bank storage with a COLLECT / HOLD FSM
    // -------------------------------------------------------------------------
    typedef enum logic {
        COLLECT = 1'b0,
        HOLD    = 1'b1
    } state_e;

    state_e               state_q, state_d;
    logic [RES_WIDTH-1:0] mem_q [ELEMENTS_NUM][ELEMENTS_NUM];

    always_comb begin
        state_d = state_q;
        case (state_q)
            COLLECT: if (complete)   state_d = HOLD;
            HOLD:    if (result_ack) state_d = COLLECT;
            default:                 state_d = COLLECT;
        endcase
    end

    assign in_ready     = (state_q == COLLECT);
    assign result_valid = (state_q == HOLD);
    assign rd_word      = mem_q[rd_r_idx][rd_c_idx];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= COLLECT;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: the storage array has no reset; its contents are undefined until
    // written, and leaving it off the reset net keeps it plain registers.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[row_q][col_q] <= in_data;
        end
    end
`endif

    // -------------------------------------------------------------------------
    // Common state registers
    // -------------------------------------------------------------------------
    // NOTE: sequential state is updated only with non-blocking assignments so
    // every flop samples the pre-edge value of every other flop.
    always_ff @(posedge clk) begin
        if (rst) begin
            row_q       <= '0;
            col_q       <= '0;
            mat_count_q <= '0;
            err_last_q  <= 1'b0;
            rd_data_q   <= '0;
        end else begin
            row_q       <= row_d;
            col_q       <= col_d;
            mat_count_q <= mat_count_d;
            err_last_q  <= err_last_d;
            rd_data_q   <= rd_data_d;
        end
    end

    assign rd_data   = rd_data_q;
    assign mat_count = mat_count_q;
    assign err_last  = err_last_q;

endmodule

// File: tb/tb_mat_result_collector.sv
// -----------------------------------------------------------------------------
// tb_mat_result_collector
//
// Self-checking bench for mat_result_collector (N=3, DATA_WIDTH=4). A
// behavioural model tracks the matrix as a running beat count, a queue of
// held banks and a plain array of stored values; every cycle the DUT outputs
// are compared against it. Directed sequences cover the basic scenarios,
// followed by a randomized phase. Build with +define+COLLECTOR_PINGPONG_EN
// to exercise the two-bank variant.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_mat_result_collector;

    localparam int N  = 3;
    localparam int DW = 4;
    localparam int RW = DW*2 + $clog2(N) + 1;
    localparam int IW = $clog2(N);
`ifdef COLLECTOR_PINGPONG_EN
    localparam int CAP = 2;
`else
    localparam int CAP = 1;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic [RW-1:0] in_data;
    logic          in_valid;
    logic          in_last;
    logic          in_ready;
    logic          result_valid;
    logic          result_ack;
    logic [IW-1:0] rd_row;
    logic [IW-1:0] rd_col;
    logic [RW-1:0] rd_data;
    logic [15:0]   mat_count;
    logic          err_last;
    logic          err_clr;

    always #5 clk = ~clk;

    mat_result_collector #(
        .ELEMENTS_NUM (N),
        .DATA_WIDTH   (DW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_last      (in_last),
        .in_ready     (in_ready),
        .result_valid (result_valid),
        .result_ack   (result_ack),
        .rd_row       (rd_row),
        .rd_col       (rd_col),
        .rd_data      (rd_data),
        .mat_count    (mat_count),
        .err_last     (err_last),
        .err_clr      (err_clr)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model
    logic [RW-1:0] m_mem   [2][N][N];
    bit            m_known [2][N][N];
    int            held[$];     // bank ids of held matrices, oldest first
    int            m_k;         // beats accepted into the current matrix
    int            m_bank;      // bank being collected
    bit            m_err;
    int            m_cnt;
    logic [RW-1:0] m_rd;
    bit            m_rd_known;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic check_outputs();
        check("in_ready",     32'(in_ready),     32'(held.size() < CAP));
        check("result_valid", 32'(result_valid), 32'(held.size() > 0));
        check("mat_count",    32'(mat_count),    32'(m_cnt));
        check("err_last",     32'(err_last),     32'(m_err));
        if (m_rd_known) check("rd_data", 32'(rd_data), 32'(m_rd));
    endtask

    // One clock cycle: drive inputs, advance the model across the edge,
    // then compare outputs on the falling edge.
    task automatic cycle(input bit v, input logic [RW-1:0] d, input bit l,
                         input bit ack, input bit clr, input int r, input int c);
        bit acc;
        bit pop;
        bit new_err;
        int rb;
        in_valid   = v;
        in_data    = d;
        in_last    = l;
        result_ack = ack;
        err_clr    = clr;
        rd_row     = IW'(r);
        rd_col     = IW'(c);

        // Read sees the pre-edge contents of the oldest held bank.
        rb = (held.size() > 0) ? held[0] : m_bank;
        if (r >= N || c >= N) begin
            m_rd       = '0;
            m_rd_known = 1'b1;
        end else begin
            m_rd       = m_mem[rb][r][c];
            m_rd_known = m_known[rb][r][c] && (CAP == 1 || held.size() > 0);
        end

        acc     = v && (held.size() < CAP);
        pop     = ack && (held.size() > 0);
        new_err = 1'b0;

        @(posedge clk);
        if (pop) void'(held.pop_front());
        if (acc) begin
            m_mem[m_bank][m_k / N][m_k % N]   = d;
            m_known[m_bank][m_k / N][m_k % N] = 1'b1;
            m_k++;
            if (m_k == N*N) begin
                new_err = !l;
                held.push_back(m_bank);
                m_cnt = (m_cnt + 1) % 65536;
                m_k   = 0;
                if (CAP == 2) m_bank = 1 - m_bank;
            end else if (l) begin
                new_err = 1'b1;
                m_k     = 0;
            end
        end
        m_err = new_err ? 1'b1 : (clr ? 1'b0 : m_err);

        @(negedge clk);
        check_outputs();
    endtask

    task automatic beat(input int d, input bit l);
        cycle(1'b1, RW'(d), l, 1'b0, 1'b0, 0, 0);
    endtask

    task automatic idle(input bit ack, input bit clr, input int r, input int c);
        cycle(1'b0, '0, 1'b0, ack, clr, r, c);
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        in_valid   = 1'b0;
        in_data    = '0;
        in_last    = 1'b0;
        result_ack = 1'b0;
        err_clr    = 1'b0;
        rd_row     = '0;
        rd_col     = '0;
        @(posedge clk);
        @(negedge clk);
        rst        = 1'b0;
        held.delete();
        m_k        = 0;
        m_bank     = 0;
        m_err      = 1'b0;
        m_cnt      = 0;
        m_rd       = '0;
        m_rd_known = 1'b1;
        check_outputs();
    endtask

    initial begin
        bit v, l, ack, clr;
        logic [RW-1:0] d;

        rst = 1'b1;
        @(negedge clk);
        do_reset();
        check("rst_ready", 32'(in_ready),     32'd1);
        check("rst_valid", 32'(result_valid), 32'd0);
        check("rst_rd",    32'(rd_data),      32'd0);
        check("rst_cnt",   32'(mat_count),    32'd0);
        check("rst_err",   32'(err_last),     32'd0);

        // Basic matrix 1..9
        for (int i = 1; i <= 9; i++) beat(i, i == 9);
        check("done_valid", 32'(result_valid), 32'd1);
        check("done_ready", 32'(in_ready),     (CAP == 1) ? 32'd0 : 32'd1);
        check("done_cnt",   32'(mat_count),    32'd1);
        idle(1'b0, 1'b0, 0, 0);
        check("rd_0_0", 32'(rd_data), 32'd1);
        idle(1'b0, 1'b0, 1, 2);
        check("rd_1_2", 32'(rd_data), 32'd6);
        idle(1'b0, 1'b0, 2, 2);
        check("rd_2_2", 32'(rd_data), 32'd9);
        idle(1'b0, 1'b0, 3, 1);
        check("rd_oor", 32'(rd_data), 32'd0);

        // Pushing into a held matrix
        for (int i = 0; i < 5; i++) beat(15, 1'b0);
        idle(1'b0, 1'b0, 0, 0);
        check("hold_rd_0_0", 32'(rd_data), 32'd1);
        idle(1'b1, 1'b0, 0, 0);
        check("ack_ready", 32'(in_ready), 32'd1);

        // Early in_last on beat 4
        do_reset();
        for (int i = 1; i <= 4; i++) beat(i, i == 4);
        check("early_err",   32'(err_last),     32'd1);
        check("early_valid", 32'(result_valid), 32'd0);
        check("early_cnt",   32'(mat_count),    32'd0);
        for (int i = 1; i <= 9; i++) beat(30 + i, i == 9);
        check("clean_valid", 32'(result_valid), 32'd1);
        check("clean_err",   32'(err_last),     32'd1);
        check("clean_cnt",   32'(mat_count),    32'd1);
        idle(1'b1, 1'b0, 1, 1);
        check("clean_rd_1_1", 32'(rd_data), 32'd35);
        idle(1'b0, 1'b1, 0, 0);
        check("clr_err", 32'(err_last), 32'd0);

        // Gapped beats without in_last
        do_reset();
        for (int i = 0; i < 9; i++) begin
            beat(50 + i, 1'b0);
            idle(1'b0, 1'b0, 0, 0);
        end
        check("gap_valid", 32'(result_valid), 32'd1);
        check("gap_err",   32'(err_last),     32'd1);

        // Reset mid-matrix
        do_reset();
        for (int i = 1; i <= 5; i++) beat(i, 1'b0);
        do_reset();
        check("mid_rst_ready", 32'(in_ready),  32'd1);
        check("mid_rst_err",   32'(err_last),  32'd0);
        check("mid_rst_cnt",   32'(mat_count), 32'd0);
        for (int i = 0; i < 9; i++) beat(20 + i, i == 8);
        idle(1'b0, 1'b0, 0, 0);
        check("fresh_rd_0_0", 32'(rd_data), 32'd20);

`ifdef COLLECTOR_PINGPONG_EN
        // Two matrices back-to-back with no ack
        do_reset();
        for (int i = 0; i < 18; i++) begin
            if (i >= 9) check("pp_ready_m2", 32'(in_ready), 32'd1);
            beat(100 + i, (i == 8) || (i == 17));
        end
        check("pp_full_ready", 32'(in_ready), 32'd0);
        check("pp_cnt",        32'(mat_count), 32'd2);
        idle(1'b1, 1'b0, 0, 0);
        check("pp_ack_ready", 32'(in_ready),     32'd1);
        check("pp_ack_valid", 32'(result_valid), 32'd1);
        idle(1'b0, 1'b0, 0, 0);
        check("pp_rd_0_0", 32'(rd_data), 32'd109);
        idle(1'b0, 1'b0, 2, 2);
        check("pp_rd_2_2", 32'(rd_data), 32'd117);
`endif

        // Randomized phase
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                do_reset();
            end else begin
                v   = ($urandom_range(0, 9) < 7);
                d   = RW'($urandom);
                l   = (m_k == N*N - 1) ? ($urandom_range(0, 19) != 0)
                                       : ($urandom_range(0, 39) == 0);
                ack = ($urandom_range(0, 4) == 0);
                clr = ($urandom_range(0, 19) == 0);
                cycle(v, d, l, ack, clr, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
